// File: rtl/piso_arb_if.sv
// Handshake and serial-lane bundle for piso_arb_ctrl.
// master: the requester / lane-consumer side; slave: the controller side.
interface piso_arb_if #(
  parameter int WIDTH = 5
);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_data;
  logic             req1_ready;
  logic             sout;
  logic             sout_valid;
  logic             sout_first;
  logic             sout_last;
  logic             sout_src;
  logic             busy;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    input  req0_ready, req1_ready,
    input  sout, sout_valid, sout_first, sout_last, sout_src, busy
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    output req0_ready, req1_ready,
    output sout, sout_valid, sout_first, sout_last, sout_src, busy
  );
endinterface

// File: rtl/piso_arb_ctrl.sv
// Two-requester round-robin arbiter feeding one MSB-first PISO serial lane.
// Each granted word is loaded into the shift register and streamed out with
// first/last markers; a new word may be accepted on the final bit of a frame
// so consecutive frames run with no idle cycle.
// Optional feature: define PISO_PARITY_EN to append one even-parity bit per
// frame (sout_last then marks the parity bit, and the accept window moves to it).
module piso_arb_ctrl #(
  parameter int WIDTH = 5
) (
  input  logic      clk,
  input  logic      rst_n,
  piso_arb_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
`ifndef PISO_PARITY_EN
  localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(WIDTH - 2);
`endif

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  // Even parity over a full data word.
  function automatic logic even_parity(input logic [WIDTH-1:0] w);
    return ^w;
  endfunction

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last_srv_q, last_srv_d;
  logic               sout_q, sout_d;
  logic               vld_q, vld_d;
  logic               first_q, first_d;
  logic               last_q, last_d;
  logic               src_q, src_d;
  logic signed [WIDTH-1:0] shreg_q, shreg_d;
`ifdef PISO_PARITY_EN
  logic               par_q, par_d;
`endif

  logic               accept_win;
  logic               gnt_any;
  logic               gnt_idx;
  logic               xfer;
  logic [WIDTH-1:0]   gnt_data;

  // Grant and accept window: purely combinational from valids and pointer.
  always_comb begin
`ifdef PISO_PARITY_EN
    accept_win = (state_q == IDLE) || (state_q == PARITY);
`else
    accept_win = (state_q == IDLE) || ((state_q == SHIFT) && (cnt_q == CNT_LAST));
`endif
    gnt_any  = bus.req0_valid | bus.req1_valid;
    // On a tie the requester that was not served last wins.
    gnt_idx  = (bus.req0_valid && bus.req1_valid) ? ~last_srv_q : bus.req1_valid;
    xfer     = accept_win && gnt_any;
    gnt_data = gnt_idx ? bus.req1_data : bus.req0_data;
  end

  assign bus.req0_ready = xfer && !gnt_idx;
  assign bus.req1_ready = xfer &&  gnt_idx;

  // Next-state and next-output logic for the load/shift sequencer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_srv_d = last_srv_q;
    sout_d     = sout_q;
    vld_d      = vld_q;
    first_d    = first_q;
    last_d     = last_q;
    src_d      = src_q;
    shreg_d    = shreg_q;
`ifdef PISO_PARITY_EN
    par_d      = par_q;
`endif
    if (xfer) begin
      // Load: the MSB goes straight to sout, the rest waits in the register.
      state_d    = SHIFT;
      cnt_d      = '0;
      last_srv_d = gnt_idx;
      src_d      = gnt_idx;
      sout_d     = gnt_data[WIDTH-1];
      shreg_d    = {gnt_data[WIDTH-2:0], 1'b0};
      vld_d      = 1'b1;
      first_d    = 1'b1;
      last_d     = 1'b0;
`ifdef PISO_PARITY_EN
      par_d      = even_parity(gnt_data);
`endif
    end else begin
      case (state_q)
        IDLE: begin
          sout_d  = 1'b0;
          vld_d   = 1'b0;
          first_d = 1'b0;
          last_d  = 1'b0;
        end
        SHIFT: begin
          if (cnt_q == CNT_LAST) begin
`ifdef PISO_PARITY_EN
            state_d = PARITY;
            sout_d  = par_q;
            vld_d   = 1'b1;
            first_d = 1'b0;
            last_d  = 1'b1;
`else
            state_d = IDLE;
            sout_d  = 1'b0;
            vld_d   = 1'b0;
            first_d = 1'b0;
            last_d  = 1'b0;
`endif
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            sout_d  = shreg_q[WIDTH-1];
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            vld_d   = 1'b1;
            first_d = 1'b0;
`ifdef PISO_PARITY_EN
            last_d  = 1'b0;
`else
            last_d  = (cnt_q == CNT_PENULT);
`endif
          end
        end
`ifdef PISO_PARITY_EN
        PARITY: begin
          state_d = IDLE;
          sout_d  = 1'b0;
          vld_d   = 1'b0;
          first_d = 1'b0;
          last_d  = 1'b0;
        end
`endif
        default: begin
          state_d = IDLE;
          sout_d  = 1'b0;
          vld_d   = 1'b0;
          first_d = 1'b0;
          last_d  = 1'b0;
        end
      endcase
    end
  end

  // Control and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_srv_q <= 1'b1;
      sout_q     <= 1'b0;
      vld_q      <= 1'b0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      src_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_srv_q <= last_srv_d;
      sout_q     <= sout_d;
      vld_q      <= vld_d;
      first_q    <= first_d;
      last_q     <= last_d;
      src_q      <= src_d;
    end
  end

  // Datapath registers; their contents are ignored outside SHIFT/PARITY.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
`ifdef PISO_PARITY_EN
    par_q   <= par_d;
`endif
  end

  assign bus.sout       = sout_q;
  assign bus.sout_valid = vld_q;
  assign bus.sout_first = first_q;
  assign bus.sout_last  = last_q;
  assign bus.sout_src   = src_q;
  assign bus.busy       = vld_q;

endmodule

// File: tb/tb_piso_arb_ctrl.sv
// Self-checking bench for piso_arb_ctrl: directed scenarios plus a randomized
// run checked against a frame-queue reference model.
module tb_piso_arb_ctrl;

  localparam int W = 5;
`ifdef PISO_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  piso_arb_if #(.WIDTH(W)) bus ();

  piso_arb_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {sout, sout_valid, sout_first, sout_last, sout_src, busy}
  logic [5:0] obs;
  assign obs = {bus.sout, bus.sout_valid, bus.sout_first, bus.sout_last, bus.sout_src, bus.busy};
  logic [1:0] rdy;
  assign rdy = {bus.req0_ready, bus.req1_ready};

  // Bit i of the serial frame for word w (index W is the parity bit).
  function automatic logic exp_bit(input logic [W-1:0] w, input int i);
    if (i < W) return w[W-1-i];
    return ^w;
  endfunction

  // ---------------- reference model ----------------
  typedef struct packed {
    logic b;
    logic first;
    logic last;
    logic src;
  } ent_t;

  ent_t mq[$];
  ent_t mcur;
  logic mcur_v;
  logic mlast;
  logic msrc;

  function automatic void m_reset();
    mq.delete();
    mcur   = '0;
    mcur_v = 1'b0;
    mlast  = 1'b1;
    msrc   = 1'b0;
  endfunction

  // Returns {ready0, ready1}.
  function automatic logic [1:0] m_ready(input logic v0, input logic v1);
    logic win;
    logic g;
    win = !mcur_v || mcur.last;
    if (!win || !(v0 || v1)) return 2'b00;
    g = (v0 && v1) ? !mlast : v1;
    return g ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [5:0] m_out();
    return {mcur_v & mcur.b, mcur_v, mcur_v & mcur.first, mcur_v & mcur.last, msrc, mcur_v};
  endfunction

  // Advance one clock edge; acc reports which requester was accepted.
  function automatic logic [1:0] m_edge(input logic v0, input logic [W-1:0] d0,
                                        input logic v1, input logic [W-1:0] d1);
    logic [1:0] r;
    logic [W-1:0] w;
    logic g;
    ent_t e;
    r = m_ready(v0, v1);
    if ((r[1] && v0) || (r[0] && v1)) begin
      g = r[0];
      w = g ? d1 : d0;
      mq.delete();
      for (int i = 0; i < FL; i++) begin
        e.b     = exp_bit(w, i);
        e.first = (i == 0);
        e.last  = (i == FL - 1);
        e.src   = g;
        mq.push_back(e);
      end
      mcur   = mq.pop_front();
      mcur_v = 1'b1;
      mlast  = g;
      msrc   = g;
      return r & {v0, v1};
    end
    if (mq.size() > 0) begin
      mcur = mq.pop_front();
    end else begin
      mcur_v = 1'b0;
      mcur   = '0;
    end
    return 2'b00;
  endfunction

  // ---------------- helpers ----------------
  task automatic idle_inputs();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_data  = '0;
    bus.req1_data  = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want %b", obs, 6'b0);
    end
    bus.req0_valid = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (rdy !== 2'b10) begin
      errors++;
      $display("FAIL reset_ready: got %b want %b", rdy, 2'b10);
    end
    bus.req0_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (obs !== 6'b0) begin
      errors++;
      $display("FAIL reset_idle_after_release: got %b want %b", obs, 6'b0);
    end
  endtask

  task automatic test_single();
    logic [W-1:0] w;
    logic [5:0] e;
    w = 5'b10110;
    bus.req0_valid = 1'b1;
    bus.req0_data  = w;
    @(negedge clk);
    checks++;
    if (rdy !== 2'b10) begin
      errors++;
      $display("FAIL single_ready: got %b want %b", rdy, 2'b10);
    end
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b0;
    for (int i = 0; i < FL; i++) begin
      e = {exp_bit(w, i), 1'b1, (i == 0), (i == FL - 1), 1'b0, 1'b1};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL single_bit%0d: got %b want %b", i, obs, e);
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (obs !== 6'b000000) begin
      errors++;
      $display("FAIL single_idle: got %b want %b", obs, 6'b0);
    end
  endtask

  task automatic test_tie_back_to_back();
    logic [W-1:0] w0;
    logic [W-1:0] w1;
    logic [5:0] e;
    int vcount;
    apply_reset();
    w0 = 5'b11111;
    w1 = 5'b00001;
    bus.req0_valid = 1'b1;
    bus.req0_data  = w0;
    bus.req1_valid = 1'b1;
    bus.req1_data  = w1;
    @(negedge clk);
    checks++;
    if (rdy !== 2'b10) begin
      errors++;
      $display("FAIL tie_first_grant: got %b want %b", rdy, 2'b10);
    end
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b0;
    vcount = 0;
    for (int i = 0; i < 2 * FL; i++) begin
      e = {(i < FL) ? exp_bit(w0, i) : exp_bit(w1, i - FL), 1'b1,
           ((i % FL) == 0), ((i % FL) == FL - 1), (i >= FL), 1'b1};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL tie_bit%0d: got %b want %b", i, obs, e);
      end
      if (bus.sout_valid) vcount++;
      @(negedge clk);
      if (bus.req1_valid) begin
        checks++;
        if (bus.req1_ready !== (i == FL - 1)) begin
          errors++;
          $display("FAIL tie_req1_ready_c%0d: got %b want %b", i, bus.req1_ready, (i == FL - 1));
        end
      end
      @(posedge clk);
      #1;
      if (i == FL - 1) bus.req1_valid = 1'b0;
    end
    checks++;
    if (vcount !== 2 * FL || bus.sout_valid !== 1'b0) begin
      errors++;
      $display("FAIL tie_valid_run: got %0d cycles (tail %b) want %0d (tail 0)", vcount, bus.sout_valid, 2 * FL);
    end
  endtask

  task automatic test_fairness();
    int acc[$];
    int srcs[$];
    int cyc;
    logic a0;
    logic a1;
    bus.req0_valid = 1'b1;
    bus.req0_data  = W'($urandom);
    bus.req1_valid = 1'b1;
    bus.req1_data  = W'($urandom);
    cyc = 0;
    while (acc.size() < 4 && cyc < 8 * FL) begin
      @(negedge clk);
      a0 = bus.req0_valid && bus.req0_ready;
      a1 = bus.req1_valid && bus.req1_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (bus.sout_first) srcs.push_back(int'(bus.sout_src));
      if (a0) begin
        acc.push_back(0);
        bus.req0_data = W'($urandom);
      end
      if (a1) begin
        acc.push_back(1);
        bus.req1_data = W'($urandom);
      end
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    while (bus.sout_valid && cyc < 20 * FL) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.sout_first) srcs.push_back(int'(bus.sout_src));
    end
    checks++;
    if (acc.size() != 4 || srcs.size() != 4) begin
      errors++;
      $display("FAIL fair_count: got %0d grants / %0d frames want 4 / 4", acc.size(), srcs.size());
    end
    for (int k = 0; k < 4; k++) begin
      if (k < acc.size() && k < srcs.size()) begin
        checks++;
        if (acc[k] != (k % 2) || srcs[k] != (k % 2)) begin
          errors++;
          $display("FAIL fair_grant%0d: got grant %0d src %0d want %0d", k, acc[k], srcs[k], k % 2);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] w0;
    logic [W-1:0] w1;
    logic [W-1:0] got;
    int n1;
    int vcount;
    w0 = 5'b11000;
    w1 = 5'b01010;
    bus.req0_valid = 1'b1;
    bus.req0_data  = w0;
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1;
    bus.req1_data  = w1;
    vcount = 1;
    for (int i = 0; i < FL; i++) begin
      @(negedge clk);
      checks++;
      if (bus.req1_ready !== (i == FL - 1)) begin
        errors++;
        $display("FAIL stall_ready_c%0d: got %b want %b", i, bus.req1_ready, (i == FL - 1));
      end
      @(posedge clk);
      #1;
      if (i == FL - 1) bus.req1_valid = 1'b0;
      if (bus.sout_valid) vcount++;
    end
    got = '0;
    n1 = 0;
    if (bus.sout_valid && bus.sout_src) begin
      got = {got[W-2:0], bus.sout};
      n1++;
    end
    for (int i = 0; i < FL + 3; i++) begin
      @(posedge clk);
      #1;
      if (bus.sout_valid) vcount++;
      if (bus.sout_valid && bus.sout_src && n1 < W) begin
        got = {got[W-2:0], bus.sout};
        n1++;
      end
    end
    checks++;
    if (got !== w1 || vcount != 2 * FL) begin
      errors++;
      $display("FAIL stall_req1_frame: got %b over %0d valid cycles want %b over %0d", got, vcount, w1, 2 * FL);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] w;
    w = 5'b11011;
    bus.req0_valid = 1'b1;
    bus.req0_data  = w;
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (obs !== {exp_bit(w, 2), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL rstmid_third_bit: got %b want %b", obs, {exp_bit(w, 2), 5'b10001});
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 6'b0) begin
      errors++;
      $display("FAIL rstmid_outputs: got %b want %b", obs, 6'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
      checks++;
      if (obs !== 6'b0) begin
        errors++;
        $display("FAIL rstmid_residual: got %b want %b", obs, 6'b0);
      end
    end
    bus.req0_valid = 1'b1;
    bus.req0_data  = 5'b00111;
    bus.req1_valid = 1'b1;
    bus.req1_data  = 5'b11100;
    #1;
    checks++;
    if (rdy !== 2'b10) begin
      errors++;
      $display("FAIL rstmid_pending_ready: got %b want %b", rdy, 2'b10);
    end
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    repeat (3 * FL) @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic [1:0] er;
    logic [1:0] acc;
    logic [5:0] eo;
    int frames;
    apply_reset();
    m_reset();
    frames = 0;
    for (int i = 0; i < 400; i++) begin
      if (!bus.req0_valid && $urandom_range(0, 2) == 0) begin
        bus.req0_valid = 1'b1;
        bus.req0_data  = W'($urandom);
      end else if (bus.req0_valid && $urandom_range(0, 15) == 0) begin
        bus.req0_valid = 1'b0;
      end
      if (!bus.req1_valid && $urandom_range(0, 2) == 0) begin
        bus.req1_valid = 1'b1;
        bus.req1_data  = W'($urandom);
      end else if (bus.req1_valid && $urandom_range(0, 15) == 0) begin
        bus.req1_valid = 1'b0;
      end
      @(negedge clk);
      er = m_ready(bus.req0_valid, bus.req1_valid);
      checks++;
      if (rdy !== er) begin
        errors++;
        $display("FAIL rand_ready_c%0d: got %b want %b", i, rdy, er);
      end
      @(posedge clk);
      acc = m_edge(bus.req0_valid, bus.req0_data, bus.req1_valid, bus.req1_data);
      #1;
      if (acc[1]) bus.req0_valid = 1'b0;
      if (acc[0]) bus.req1_valid = 1'b0;
      if (acc != 2'b00) frames++;
      eo = m_out();
      checks++;
      if (obs !== eo) begin
        errors++;
        $display("FAIL rand_out_c%0d: got %b want %b", i, obs, eo);
      end
      if (i == 200) begin
        rst_n = 1'b0;
        m_reset();
        #1;
        checks++;
        if (obs !== 6'b0) begin
          errors++;
          $display("FAIL rand_reset_out: got %b want %b", obs, 6'b0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
      end
    end
    checks++;
    if (frames < 20) begin
      errors++;
      $display("FAIL rand_activity: got %0d frames want at least 20", frames);
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_tie_back_to_back();
    test_fairness();
    test_stall();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
